// File: rtl/hilo_div_issue_ctrl_if.sv
// hilo_div_issue_ctrl_if: ID-side decode inputs, divider handshake and status outputs of the divide issue controller
// master: the controller (drives div_start, hilo_we, stall, busy, div_err, wait_cnt)
// slave:  the pipeline/divider side (drives id_valid, id_funct, id_flush, div_done)
interface hilo_div_issue_ctrl_if #(parameter int CNT_W = 6);
  logic             id_valid;
  logic [5:0]       id_funct;
  logic             id_flush;
  logic             div_done;
  logic             div_start;
  logic             hilo_we;
  logic             stall;
  logic             busy;
  logic             div_err;
  logic [CNT_W-1:0] wait_cnt;
  modport master (
    input  id_valid, id_funct, id_flush, div_done,
    output div_start, hilo_we, stall, busy, div_err, wait_cnt
  );
  modport slave (
    output id_valid, id_funct, id_flush, div_done,
    input  div_start, hilo_we, stall, busy, div_err, wait_cnt
  );
endinterface

// File: rtl/hilo_div_issue_ctrl.sv
// hilo_div_issue_ctrl: launches DIVU on the divider, waits for done, commits HI/LO, stalls ID on racing HI/LO users
// ports: clk, reset (sync, active-high), bus (master modport):
//   in  id_valid, id_funct, id_flush, div_done
//   out div_start, hilo_we, stall (combinational), busy, div_err (sticky), wait_cnt
module hilo_div_issue_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input logic                  clk,
  input logic                  reset,
  hilo_div_issue_ctrl_if.master bus
);
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             div_err;
  logic             accept;
  logic             hazard;
  assign accept = bus.id_valid & ~bus.id_flush;
  assign hazard = accept & (bus.id_funct == DIVU | bus.id_funct == MFHI | bus.id_funct == MFLO);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      div_err  <= 1'b0;
    end else begin
      case (state)
        IDLE:   state <= (accept && bus.id_funct == DIVU) ? ISSUE : IDLE;
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // done takes priority over a simultaneous timeout
          if (bus.div_done) state <= COMMIT;
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= IDLE;
            div_err <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.div_start = state == ISSUE;
  assign bus.hilo_we   = state == COMMIT;
  assign bus.busy      = state != IDLE;
  assign bus.stall     = hazard & (state != IDLE);
  assign bus.div_err   = div_err;
  assign bus.wait_cnt  = wait_cnt;
endmodule
